shift_serializer: RTL and testbench
===================================

# shift_serializer

Parallel-to-serial transmitter that accepts an N-bit word over a valid/ready handshake and emits it one bit per clock, LSB-first or MSB-first. It sits directly upstream of the team's n-bit shift register stage. SerialOut drives that register's serial-fill input W, and SerialValid gates its shift command. The block keeps its own word register and bit counter, so it can be verified standalone.

## Interface
- N, default 8, word width; legal range N >= 2.
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately, independent of Clock.
- Data  in  N  parallel word; sampled only on an accepting edge.
- Valid  in  1  upstream offers Data this cycle.
- Dir  in  1  bit order, sampled with Data: 0 = LSB-first (right shift), 1 = MSB-first (left shift).
- Hold  in  1  pause; while high in SHIFT, no bit is consumed (equivalent to "no change").
- Ready  out  1  block can accept a word this cycle.
- SerialOut  out  1  current serial bit.
- SerialValid  out  1  SerialOut is a live bit to be consumed at the next edge.
- Done  out  1  one-cycle pulse after the last bit of a word has been consumed.

## Operation
- Internal state: mode (IDLE, SHIFT), word register W[N-1:0], latched direction D, bit counter C of width clog2(N), Done flag.
- Ready = (mode == IDLE) and not Reset.
- Accept: an edge with Valid = 1 and Ready = 1 does the following:
  - W <= Data, D <= Dir, C <= 0, mode <= SHIFT.
- SerialOut:
  - In SHIFT: W[0] when D = 0, W[N-1] when D = 1.
  - In IDLE: 0.
- SerialValid = (mode == SHIFT) and not Hold.
- Each edge in SHIFT with Hold = 0:
  - W shifts toward the output end: right when D = 0, left when D = 1; the vacated bit fills with 0.
  - If C == N-1: mode <= IDLE, Done <= 1. Otherwise C <= C+1.
- Each edge in SHIFT with Hold = 1: W, C, D and mode are unchanged.
- Done register: set only on the last-bit edge; cleared on every other edge.
- In SHIFT, Valid and Data are ignored because Ready = 0; no word is lost or queued.
- Hold in IDLE has no effect.
- Dir changes during SHIFT have no effect; the latched D governs the whole word.
- Reset, asynchronous and allowed at any time including mid-word:
  - mode = IDLE, W = 0, C = 0, D = 0, Done = 0.
  - Outputs: SerialOut = 0, SerialValid = 0, Done = 0, Ready = 0 while Reset is high and 1 after release.
  - A partially sent word is discarded; there is no Done for it.

## Timing
- Accept at edge k; bit 0 of the word (LSB if D = 0, MSB if D = 1) is on SerialOut during cycle k+1.
- With no Hold, bits occupy cycles k+1 … k+N, and the bit in cycle k+j is consumed at the edge ending that cycle.
- Done is high for exactly cycle k+N+1; Ready is also high in that cycle.
- Back-to-back throughput: the next word can be accepted at the edge ending cycle k+N+1, so the minimum period is N+1 cycles per word (one idle gap).
- Each Hold cycle in SHIFT extends the word by exactly one cycle. SerialOut holds its value during Hold; SerialValid = 0.
- Hold asserted in the cycle of the last bit delays both the mode change and Done by one cycle per Hold cycle.
- All outputs except Ready are pure functions of registered state. Ready depends combinationally only on Reset and mode, never on Valid.

## Test plan
- Reset, then reset release with Valid = 0 -> Ready = 1, SerialValid = 0, SerialOut = 0, Done = 0, held steady.
- N = 8, Data = 8'hC1, Dir = 0 -> SerialOut = 1,0,0,0,0,0,1,1 in cycles k+1…k+8, SerialValid = 1 throughout, Done = 1 only in k+9.
- N = 8, Data = 8'hC1, Dir = 1 -> SerialOut = 1,1,0,0,0,0,0,1. Toggling Dir and Data mid-word changes nothing.
- Hold high for 3 cycles after bit 2 -> SerialOut frozen at bit 2 with SerialValid = 0, remaining bits resume unchanged, Done arrives 3 cycles later (k+12).
- Valid held high continuously with two words -> second word accepted at the edge ending cycle k+9 (the Done cycle), its first bit in k+10, and no word is accepted during SHIFT.
- Reset pulse asserted asynchronously mid-word after bit 4 -> SerialValid and SerialOut drop to 0 immediately, no Done pulse, and the next accepted word transmits correctly from bit 0.

Source files
------------

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter: accepts an N-bit word on a valid/ready handshake
// and shifts it out one bit per clock, LSB-first or MSB-first.
module shift_serializer #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_data,
   input  logic         i_valid,
   input  logic         i_dir,
   input  logic         i_hold,
   output logic         o_ready,
   output logic         o_serial_out,
   output logic         o_serial_valid,
   output logic         o_done
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t        r_state;
   logic [N-1:0]  r_word;
   logic [CW-1:0] r_cnt;
   logic          r_dir;
   logic          r_done;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // in this block sees the pre-edge values of the others.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_word  <= '0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_valid) begin
                  r_word  <= i_data;
                  r_dir   <= i_dir;
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               // Hold freezes word, counter and mode; the current bit stays on the line.
               if (!i_hold) begin
                  r_word <= r_dir ? {r_word[N-2:0], 1'b0} : {1'b0, r_word[N-1:1]};
                  if (r_cnt == LAST) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   logic w_shifting;
   assign w_shifting     = (r_state == SHIFT);
   assign o_ready        = (r_state == IDLE) && !i_rst;
   assign o_serial_out   = w_shifting ? (r_dir ? r_word[N-1] : r_word[0]) : 1'b0;
   assign o_serial_valid = w_shifting && !i_hold;
   assign o_done         = r_done;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer (N = 8) with hand-computed serial sequences.
module tb_shift_serializer;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_data;
   logic       i_valid;
   logic       i_dir;
   logic       i_hold;
   logic       o_ready;
   logic       o_serial_out;
   logic       o_serial_valid;
   logic       o_done;

   int n_tests = 0;
   int n_fail  = 0;

   shift_serializer #(.N(8)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .i_dir          (i_dir),
      .i_hold         (i_hold),
      .o_ready        (o_ready),
      .o_serial_out   (o_serial_out),
      .o_serial_valid (o_serial_valid),
      .o_done         (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      n_tests++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Starts in cycle k+1 (just after the accepting edge) and ends in the Done cycle.
   // exp_seq[j] is the bit expected on the line for the j-th serial bit.
   task automatic word_body(input logic [7:0] exp_seq, input int hold_at, input int hold_len,
                            input bit toggle);
      for (int j = 0; j < 8; j++) begin
         for (int h = 0; h < ((j == hold_at) ? hold_len : 0); h++) begin
            i_hold = 1'b1;
            #1;
            check($sformatf("hold%0d_sv", h), o_serial_valid, 1'b0);
            check($sformatf("hold%0d_so", h), o_serial_out, exp_seq[j]);
            check($sformatf("hold%0d_done", h), o_done, 1'b0);
            step();
         end
         i_hold = 1'b0;
         if (toggle) begin
            i_data = ~i_data;
            i_dir  = ~i_dir;
         end
         #1;
         check($sformatf("bit%0d_so", j), o_serial_out, exp_seq[j]);
         check($sformatf("bit%0d_sv", j), o_serial_valid, 1'b1);
         check($sformatf("bit%0d_done", j), o_done, 1'b0);
         check($sformatf("bit%0d_ready", j), o_ready, 1'b0);
         step();
      end
      check("done_pulse", o_done, 1'b1);
      check("done_ready", o_ready, 1'b1);
      check("done_sv", o_serial_valid, 1'b0);
      check("done_so", o_serial_out, 1'b0);
   endtask

   task automatic accept(input logic [7:0] data, input logic dir);
      i_data  = data;
      i_dir   = dir;
      i_valid = 1'b1;
      #1;
      check("pre_accept_ready", o_ready, 1'b1);
      step();
   endtask

   initial begin
      i_rst   = 1'b1;
      i_data  = 8'h00;
      i_valid = 1'b0;
      i_dir   = 1'b0;
      i_hold  = 1'b0;
      #12;
      check("rst_ready", o_ready, 1'b0);
      check("rst_sv", o_serial_valid, 1'b0);
      check("rst_so", o_serial_out, 1'b0);
      check("rst_done", o_done, 1'b0);
      #6 i_rst = 1'b0;
      i_hold = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         check("idle_ready", o_ready, 1'b1);
         check("idle_sv", o_serial_valid, 1'b0);
         check("idle_so", o_serial_out, 1'b0);
         check("idle_done", o_done, 1'b0);
         step();
      end
      i_hold = 1'b0;

      // LSB-first 8'hC1: 1,0,0,0,0,0,1,1
      accept(8'hC1, 1'b0);
      i_valid = 1'b0;
      word_body(8'hC1, -1, 0, 1'b0);
      step();
      check("after_done_lsb", o_done, 1'b0);

      // MSB-first 8'hC1: 1,1,0,0,0,0,0,1 -> bit j of 8'h83; Dir/Data toggled mid-word
      accept(8'hC1, 1'b1);
      i_valid = 1'b0;
      word_body(8'h83, -1, 0, 1'b1);
      step();
      check("after_done_msb", o_done, 1'b0);

      // 3-cycle hold on bit 2, LSB-first 8'hC1; Done lands in k+12
      accept(8'hC1, 1'b0);
      i_valid = 1'b0;
      word_body(8'hC1, 2, 3, 1'b0);
      step();
      check("after_done_hold", o_done, 1'b0);

      // Valid held high: 8'hA5 LSB-first (1,0,1,0,0,1,0,1), then 8'h35 MSB-first
      // (0,0,1,1,0,1,0,1 -> 8'hAC) accepted on the edge ending the Done cycle
      accept(8'hA5, 1'b0);
      i_data = 8'h35;
      i_dir  = 1'b1;
      word_body(8'hA5, -1, 0, 1'b0);
      step();
      i_valid = 1'b0;
      word_body(8'hAC, -1, 0, 1'b0);
      step();
      check("after_b2b", o_done, 1'b0);

      // Async reset after bit 4 of 8'h5A LSB-first (0,1,0,1,1,...)
      accept(8'h5A, 1'b0);
      i_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         check($sformatf("pre_rst_bit%0d", j), o_serial_out, ((j == 1) || (j == 3) || (j == 4)) ? 8'd1 : 8'd0);
         step();
      end
      #2 i_rst = 1'b1;
      #1;
      check("midrst_sv", o_serial_valid, 1'b0);
      check("midrst_so", o_serial_out, 1'b0);
      check("midrst_ready", o_ready, 1'b0);
      check("midrst_done", o_done, 1'b0);
      #2 i_rst = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
         check("post_rst_done", o_done, 1'b0);
         check("post_rst_ready", o_ready, 1'b1);
         step();
      end
      accept(8'hC1, 1'b1);
      i_valid = 1'b0;
      word_body(8'h83, -1, 0, 1'b0);
      step();
      check("final_done_clear", o_done, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
